// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & {{(PC_W-2){1'b1}}, 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: imem request/response, redirect input and the decoded-side stream.
interface fetch_unit_if;
  import fetch_pkg::*;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic [PC_W-1:0]    instr_pc4;
  logic               instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {instr, pc}; flush wins over push, pop alongside flush is harmless.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, fetch credit, redirect discard, in-order delivery.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d, discard_q, discard_d;
  logic [CW-1:0]   q_count;
  logic            q_full, q_empty;
  logic [CW:0]     committed;
  logic            req, accept, push, pop;
  fetch_entry_t    q_head, q_wdata;

  // Credit covers both queued words and words still in flight, so a push never finds the queue full.
  assign committed = {1'b0, q_count} + {1'b0, outst_q};
  assign req       = reset && !bus.redirect && !q_full && (committed < CAP);
  assign accept    = req && bus.imem_ready;
  assign push      = bus.imem_rvalid && !bus.redirect && (discard_q == '0);
  assign pop       = !q_empty && bus.instr_ready;
  assign q_wdata   = '{instr: bus.imem_rdata, pc: resp_pc_q};

  always_comb begin
    outst_d    = outst_q + CW'(accept) - CW'(bus.imem_rvalid);
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (bus.redirect) begin
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d  = outst_d;
      fetch_pc_d = word_align(bus.redirect_pc);
      resp_pc_d  = word_align(bus.redirect_pc);
    end else begin
      if (bus.imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push)   resp_pc_d  = resp_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = !q_empty;
  assign bus.instr       = q_empty ? '0 : q_head.instr;
  assign bus.instr_pc    = q_empty ? '0 : q_head.pc;
  assign bus.instr_pc4   = q_empty ? '0 : q_head.pc + PC_STEP;
endmodule
